// File: rtl/m_store_buffer_pkg.sv
// Shared definitions for the M-stage store buffer: store op encodings,
// the AdES exception code and the lane-index width helper.
package m_store_buffer_pkg;

   localparam logic [2:0] ST_OP_NONE = 3'b000;
   localparam logic [2:0] ST_OP_SB   = 3'b001;
   localparam logic [2:0] ST_OP_SH   = 3'b010;
   localparam logic [2:0] ST_OP_SW   = 3'b011;
   localparam logic [2:0] ST_OP_SD   = 3'b100;

   localparam logic [4:0] EXC_ADES = 5'd5;

   function automatic int lane_w(input int data_w);
      return $clog2(data_w / 8);
   endfunction

endpackage

// File: rtl/m_store_buffer_lane_align.sv
// m_store_lane_align: combinational store formatter. Maps op/lane/source data to
// byte enables and lane-aligned data, and flags misaligned or illegal ops.
module m_store_lane_align
   import m_store_buffer_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [2:0]                  op,
   input  logic [lane_w(DATA_W)-1:0]   lane,
   input  logic [DATA_W-1:0]           wdata,
   output logic [DATA_W/8-1:0]         byteen,
   output logic [DATA_W-1:0]           data,
   output logic                        bad
);

   localparam int BYTES  = DATA_W / 8;
   localparam int LANE_W = lane_w(DATA_W);

   logic [LANE_W+2:0] shamt;

   always_comb begin
      shamt  = {lane, 3'b000};
      byteen = '0;
      data   = '0;
      bad    = 1'b0;
      case (op)
         ST_OP_NONE: ;
         ST_OP_SB: begin
            byteen = BYTES'(1) << lane;
            data   = DATA_W'(wdata[7:0]) << shamt;
         end
         ST_OP_SH: begin
            bad    = lane[0];
            byteen = BYTES'(2'b11) << lane;
            data   = DATA_W'(wdata[15:0]) << shamt;
         end
         ST_OP_SW: begin
            bad    = |lane[1:0];
            byteen = BYTES'(4'hF) << lane;
            data   = DATA_W'(wdata[31:0]) << shamt;
         end
         ST_OP_SD: begin
            if (BYTES == 8) begin
               bad    = |lane;
               byteen = '1;
               data   = wdata;
            end else begin
               bad = 1'b1;
            end
         end
         default: bad = 1'b1;
      endcase
      // a rejected store never reaches the FIFO; keep its lanes quiet
      if (bad) begin
         byteen = '0;
         data   = '0;
      end
   end

endmodule

// File: rtl/m_store_buffer.sv
// m_store_buffer: M-stage store unit with a DEPTH-entry FIFO draining over req/ack,
// plus a word-address load hazard compare. Define STORE_MERGE_EN for write-combining into the tail.
module m_store_buffer
   import m_store_buffer_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32,
   parameter int DEPTH  = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     st_valid,
   output logic                     st_ready,
   input  logic [2:0]               st_op,
   input  logic [ADDR_W-1:0]        st_addr,
   input  logic [DATA_W-1:0]        st_wdata,
   output logic                     st_exc,
   output logic                     mem_req,
   output logic [ADDR_W-1:0]        mem_addr,
   output logic [DATA_W/8-1:0]      mem_byteen,
   output logic [DATA_W-1:0]        mem_wdata,
   input  logic                     mem_ack,
   input  logic [ADDR_W-1:0]        ld_addr,
   output logic                     ld_hit,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int BYTES  = DATA_W / 8;
   localparam int LANE_W = lane_w(DATA_W);
   localparam int PTR_W  = $clog2(DEPTH);
   localparam int CNT_W  = PTR_W + 1;

   localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(BYTES - 1);

   logic [ADDR_W-1:0] addr_q [DEPTH];
   logic [ADDR_W-1:0] addr_d [DEPTH];
   logic [BYTES-1:0]  be_q   [DEPTH];
   logic [BYTES-1:0]  be_d   [DEPTH];
   logic [DATA_W-1:0] data_q [DEPTH];
   logic [DATA_W-1:0] data_d [DEPTH];

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q,  count_d;

   logic [BYTES-1:0]  al_be;
   logic [DATA_W-1:0] al_data;
   logic              al_bad;

   logic [ADDR_W-1:0] st_word;
   logic [ADDR_W-1:0] ld_word;
   logic [PTR_W-1:0]  ld_idx;
   logic              st_store;
   logic              full;
   logic              merge_hit;
   logic              do_push;
   logic              do_pop;

   m_store_lane_align #(.DATA_W(DATA_W)) u_align (
      .op     (st_op),
      .lane   (st_addr[LANE_W-1:0]),
      .wdata  (st_wdata),
      .byteen (al_be),
      .data   (al_data),
      .bad    (al_bad)
   );

   assign st_word  = st_addr & WORD_MASK;
   assign ld_word  = ld_addr & WORD_MASK;
   assign st_exc   = st_valid & al_bad;
   assign st_store = st_valid & ~al_bad & (st_op != ST_OP_NONE);
   assign full     = (count_q == CNT_W'(DEPTH));

`ifdef STORE_MERGE_EN
   logic [PTR_W-1:0] tail_ptr;
   assign tail_ptr = wr_ptr_q - 1'b1;
   // count >= 2 keeps the merge target away from the head that may be in flight
   assign merge_hit = st_store & (count_q >= CNT_W'(2)) & (addr_q[tail_ptr] == st_word);
`else
   assign merge_hit = 1'b0;
`endif

   assign st_ready = ~full | merge_hit;
   assign do_push  = st_store & ~full & ~merge_hit;
   assign mem_req  = (count_q != '0);
   assign do_pop   = mem_req & mem_ack;
   assign empty    = ~mem_req;
   assign count    = count_q;

   assign mem_addr   = mem_req ? addr_q[rd_ptr_q] : '0;
   assign mem_byteen = mem_req ? be_q[rd_ptr_q]   : '0;
   assign mem_wdata  = mem_req ? data_q[rd_ptr_q] : '0;

   always_comb begin
      addr_d   = addr_q;
      be_d     = be_q;
      data_d   = data_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) begin
         addr_d[wr_ptr_q] = st_word;
         be_d[wr_ptr_q]   = al_be;
         data_d[wr_ptr_q] = al_data;
         wr_ptr_d         = wr_ptr_q + 1'b1;
      end
`ifdef STORE_MERGE_EN
      if (merge_hit) begin
         be_d[tail_ptr] = be_q[tail_ptr] | al_be;
         for (int b = 0; b < BYTES; b++) begin
            if (al_be[b]) data_d[tail_ptr][8*b +: 8] = al_data[8*b +: 8];
         end
      end
`endif
      if (do_pop) rd_ptr_d = rd_ptr_q + 1'b1;
      count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
   end

   // entry storage needs no reset: it is only observed through count-qualified paths
   always_ff @(posedge clk) begin
      addr_q <= addr_d;
      be_q   <= be_d;
      data_q <= data_d;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_comb begin
      ld_hit = 1'b0;
      ld_idx = '0;
      for (int i = 0; i < DEPTH; i++) begin
         ld_idx = rd_ptr_q + PTR_W'(i);
         if ((CNT_W'(i) < count_q) && (addr_q[ld_idx] == ld_word)) ld_hit = 1'b1;
      end
   end

endmodule

// File: tb/tb_m_store_buffer.sv
// Bench for m_store_buffer (DATA_W=32, DEPTH=4): vector table for lane/exception
// rules, scoreboard on the memory port, and hand sequences for full/hazard/merge/reset.
module tb_m_store_buffer;

   logic        clk;
   logic        reset;
   logic        st_valid;
   logic        st_ready;
   logic [2:0]  st_op;
   logic [31:0] st_addr;
   logic [31:0] st_wdata;
   logic        st_exc;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic [3:0]  mem_byteen;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] ld_addr;
   logic        ld_hit;
   logic        empty;
   logic [2:0]  count;

   m_store_buffer #(.DATA_W(32), .ADDR_W(32), .DEPTH(4)) dut (
      .clk        (clk),
      .reset      (reset),
      .st_valid   (st_valid),
      .st_ready   (st_ready),
      .st_op      (st_op),
      .st_addr    (st_addr),
      .st_wdata   (st_wdata),
      .st_exc     (st_exc),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_byteen (mem_byteen),
      .mem_wdata  (mem_wdata),
      .mem_ack    (mem_ack),
      .ld_addr    (ld_addr),
      .ld_hit     (ld_hit),
      .empty      (empty),
      .count      (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        exc;
      logic [3:0]  be;
      logic [31:0] data;
   } vec_t;

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  be;
      logic [31:0] data;
   } ent_t;

   vec_t vecs [13];
   ent_t exp_q [$];
   int   n_vec  = 0;
   int   n_miss = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // scoreboard: every handshake on the memory port must match the oldest expected store
   always @(negedge clk) begin
      if (!reset && mem_req && mem_ack) begin
         if (exp_q.size() == 0) begin
            check("unexpected mem transfer", 64'(mem_addr), 64'hFFFF_FFFF_FFFF_FFFF);
         end else begin
            ent_t e;
            e = exp_q.pop_front();
            check("mem_addr",   64'(mem_addr),   64'(e.addr));
            check("mem_byteen", 64'(mem_byteen), 64'(e.be));
            check("mem_wdata",  64'(mem_wdata),  64'(e.data));
         end
      end
   end

   function automatic ent_t mk(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
      ent_t e;
      e.addr = a & 32'hFFFF_FFFC;
      e.be   = be;
      e.data = d;
      return e;
   endfunction

   // called just after a rising edge; returns just after the accepting edge
   task automatic push(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be, input logic [31:0] d);
      st_valid = 1'b1;
      st_op    = op;
      st_addr  = a;
      st_wdata = wd;
      exp_q.push_back(mk(a, be, d));
      @(posedge clk); #1;
      st_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      mem_ack = 1'b1;
      while (!empty && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      check("drain empty", 64'(empty), 64'd1);
      check("scoreboard leftovers", 64'(exp_q.size()), 64'd0);
      mem_ack = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vecs[0]  = '{3'b001, 32'h0000_1003, 32'h0000_00AB, 1'b0, 4'b1000, 32'hAB00_0000};
      vecs[1]  = '{3'b010, 32'h0000_2001, 32'h0000_1234, 1'b1, 4'b0000, 32'h0};
      vecs[2]  = '{3'b011, 32'h0000_2002, 32'h1234_5678, 1'b1, 4'b0000, 32'h0};
      vecs[3]  = '{3'b111, 32'h0000_2000, 32'h1234_5678, 1'b1, 4'b0000, 32'h0};
      vecs[4]  = '{3'b100, 32'h0000_2000, 32'h1234_5678, 1'b1, 4'b0000, 32'h0};
      vecs[5]  = '{3'b000, 32'h0000_2000, 32'h1234_5678, 1'b0, 4'b0000, 32'h0};
      vecs[6]  = '{3'b001, 32'h0000_1000, 32'hFFFF_FF12, 1'b0, 4'b0001, 32'h0000_0012};
      vecs[7]  = '{3'b001, 32'h0000_1001, 32'h0000_0034, 1'b0, 4'b0010, 32'h0000_3400};
      vecs[8]  = '{3'b010, 32'h0000_1002, 32'hCAFE_BEEF, 1'b0, 4'b1100, 32'hBEEF_0000};
      vecs[9]  = '{3'b010, 32'h0000_1000, 32'h0000_5678, 1'b0, 4'b0011, 32'h0000_5678};
      vecs[10] = '{3'b011, 32'h0000_1004, 32'hDEAD_BEEF, 1'b0, 4'b1111, 32'hDEAD_BEEF};
      vecs[11] = '{3'b010, 32'h0000_1006, 32'h1111_A5A5, 1'b0, 4'b1100, 32'hA5A5_0000};
      vecs[12] = '{3'b001, 32'h0000_100E, 32'h0000_0077, 1'b0, 4'b0100, 32'h0077_0000};

      reset = 1'b1; st_valid = 1'b0; st_op = 3'b000; st_addr = '0; st_wdata = '0;
      mem_ack = 1'b0; ld_addr = 32'hFFFF_FFF0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("reset count",    64'(count),      64'd0);
      check("reset empty",    64'(empty),      64'd1);
      check("reset mem_req",  64'(mem_req),    64'd0);
      check("reset st_ready", 64'(st_ready),   64'd1);
      check("reset mem_addr", 64'(mem_addr),   64'd0);
      check("reset byteen",   64'(mem_byteen), 64'd0);
      check("reset wdata",    64'(mem_wdata),  64'd0);

      mem_ack = 1'b1;
      for (int i = 0; i < 13; i++) begin
         logic acc;
         acc = !vecs[i].exc && (vecs[i].op != 3'b000);
         @(posedge clk); #1;
         st_valid = 1'b1;
         st_op    = vecs[i].op;
         st_addr  = vecs[i].addr;
         st_wdata = vecs[i].wdata;
         @(negedge clk);
         check($sformatf("vec%0d st_exc", i), 64'(st_exc), 64'(vecs[i].exc));
         if (acc) exp_q.push_back(mk(vecs[i].addr, vecs[i].be, vecs[i].data));
         @(posedge clk); #1;
         st_valid = 1'b0;
         @(negedge clk);
         check($sformatf("vec%0d mem_req", i), 64'(mem_req), 64'(acc));
         @(negedge clk);
         check($sformatf("vec%0d empty", i), 64'(empty), 64'd1);
      end
      mem_ack = 1'b0;
      @(posedge clk); #1;

      // fill to DEPTH with memory stalled, then free one slot while a store waits
      for (int k = 0; k < 4; k++)
         push(3'b011, 32'h100 + 32'(4*k), 32'h1111_1111 * 32'(k+1), 4'b1111, 32'h1111_1111 * 32'(k+1));
      @(negedge clk);
      check("full count",    64'(count),    64'd4);
      check("full st_ready", 64'(st_ready), 64'd0);
      @(posedge clk); #1;
      st_valid = 1'b1; st_op = 3'b011; st_addr = 32'h110; st_wdata = 32'h5555_5555;
      mem_ack = 1'b1;
      @(negedge clk);
      check("full+ack st_ready", 64'(st_ready), 64'd0);
      @(posedge clk); #1;
      mem_ack = 1'b0;
      @(negedge clk);
      check("after pop count",    64'(count),    64'd3);
      check("after pop st_ready", 64'(st_ready), 64'd1);
      exp_q.push_back(mk(32'h110, 4'b1111, 32'h5555_5555));
      @(posedge clk); #1;
      st_valid = 1'b0;
      @(negedge clk);
      check("refill count", 64'(count), 64'd4);
      @(posedge clk); #1;
      drain();

      // load hazard on word address
      ld_addr = 32'h3002;
      @(negedge clk);
      check("ld_hit before push", 64'(ld_hit), 64'd0);
      @(posedge clk); #1;
      push(3'b010, 32'h3000, 32'h0000_BEEF, 4'b0011, 32'h0000_BEEF);
      @(negedge clk);
      check("ld_hit same word", 64'(ld_hit), 64'd1);
      @(posedge clk); #1;
      ld_addr = 32'h3004;
      @(negedge clk);
      check("ld_hit next word", 64'(ld_hit), 64'd0);
      @(posedge clk); #1;
      ld_addr = 32'h3003;
      mem_ack = 1'b1;
      @(negedge clk);
      check("ld_hit during pop", 64'(ld_hit), 64'd1);
      @(posedge clk); #1;
      check("ld_hit after pop", 64'(ld_hit), 64'd0);
      drain();
      ld_addr = 32'hFFFF_FFF0;

      // write-combining into the tail (count >= 2)
      push(3'b011, 32'h10, 32'hAAAA_AAAA, 4'b1111, 32'hAAAA_AAAA);
      push(3'b001, 32'h20, 32'h0000_0077, 4'b0001, 32'h0000_0077);
      st_valid = 1'b1; st_op = 3'b001; st_addr = 32'h21; st_wdata = 32'h0000_0055;
`ifdef STORE_MERGE_EN
      exp_q[exp_q.size()-1].be   = 4'b0011;
      exp_q[exp_q.size()-1].data = 32'h0000_5577;
`else
      exp_q.push_back(mk(32'h21, 4'b0010, 32'h0000_5500));
`endif
      @(posedge clk); #1;
      st_valid = 1'b0;
      @(negedge clk);
`ifdef STORE_MERGE_EN
      check("merge count", 64'(count), 64'd2);
`else
      check("no-merge count", 64'(count), 64'd3);
`endif
      @(posedge clk); #1;
      drain();

      // reset with an unacked head drops everything
      push(3'b011, 32'h500, 32'h0101_0101, 4'b1111, 32'h0101_0101);
      push(3'b011, 32'h504, 32'h0202_0202, 4'b1111, 32'h0202_0202);
      push(3'b011, 32'h508, 32'h0303_0303, 4'b1111, 32'h0303_0303);
      @(negedge clk);
      check("pre-reset mem_req", 64'(mem_req), 64'd1);
      check("pre-reset count",   64'(count),   64'd3);
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check("post-reset count",    64'(count),    64'd0);
      check("post-reset mem_req",  64'(mem_req),  64'd0);
      check("post-reset st_ready", 64'(st_ready), 64'd1);
      check("post-reset mem_addr", 64'(mem_addr), 64'd0);
      @(posedge clk); #1;
      push(3'b001, 32'h4002, 32'h0000_0099, 4'b0100, 32'h0099_0000);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
